trace_uart_tx: RTL
==================

# trace_uart_tx

Execution-trace transmitter at the consumer end of the core's observation ports: register writeback, data-memory read/write, and address/data. It qualifies each active cycle into a trace record and buffers records in a FIFO. It serializes each record as a fixed-length byte frame over an 8N1 UART line. It sits beside the `riscv` top in the FPGA wrapper and drives the board's UART TX pin.

## Interface
- `FIFO_DEPTH`, 16: record slots; power of two, ≥2.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); ≥2.
- `DATA_W`, 32: width of memory and register data.
- `clk` input 1: the single clock; all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `trace_en` input 1: capture enable; records are queued only while high.
- `reg_num` input 5: writeback register index.
- `reg_data` input DATA_W: writeback value.
- `reg_write_sig` input 1: writeback valid.
- `wr` input 1: data-memory store strobe.
- `rd` input 1: data-memory load strobe.
- `addr` input 9: data-memory word address.
- `wr_data` input DATA_W: store data.
- `rd_data` input DATA_W: load data.
- `tx` output 1: UART serial line, idle high.
- `busy` output 1: high while a frame is being shifted or the FIFO is non-empty.
- `overflow` output 1: sticky, set when a record is dropped.
- `drop_count` output 8: records dropped, saturates at 255.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: records currently queued.

## Operation
- Capture condition per cycle: `trace_en & (wr | rd | (reg_write_sig & reg_num != 0))`. At most one record is produced per cycle.
- Record contents:
  - header = {wr, rd, reg_write_sig & (reg_num!=0), reg_num}.
  - addr.
  - mdata = wr ? wr_data : rd_data (0 if neither).
  - rdata = reg_data.
- Frame bytes, in order:
  - header.
  - {7'b0, addr[8]}, then addr[7:0].
  - mdata[31:24] down to [7:0].
  - rdata[31:24] down to [7:0].
  - Total 11 bytes (13 with timestamp, see Configuration).
- UART byte format: start bit 0, 8 data bits LSB first, stop bit 1. The next byte's start bit follows the stop bit directly; there is no gap.
- Serializer FSM:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the record into the frame register, set byte index 0, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=current bit for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. If the byte index is the last byte, go to IDLE; else increment the index and go to START.
- FIFO full with a capture:
  - If a pop occurs the same cycle, the push is accepted.
  - Otherwise the record is dropped, `overflow` is set, and `drop_count` increments (saturating).
- Empty FIFO: IDLE holds `tx`=1 indefinitely.
- Pointers wrap modulo FIFO_DEPTH. `fifo_level` distinguishes full from empty.
- `trace_en` low stops new captures only; queued records and any frame in flight still complete.

## Timing
- Reset (asserted, asynchronous): `tx`=1, `busy`=0, `overflow`=0, `drop_count`=0, `fifo_level`=0, FSM=IDLE, FIFO emptied. A frame in flight is truncated immediately.
- A capture at edge N makes `fifo_level` increment after edge N.
- If the FSM is IDLE, the pop occurs at edge N+1 and `tx` falls after edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- A byte takes 10·CLKS_PER_BIT cycles; a frame takes 110·CLKS_PER_BIT cycles (130 with timestamp).
- Back-to-back frames: IDLE lasts 1 cycle between the last stop bit and the next start bit.
- Deassertion of `reset` is internally synchronized (2-flop) before the FSM leaves IDLE.

## Configuration
- `TRACE_TIMESTAMP_EN` defined:
  - A 16-bit free-running cycle counter (reset 0, wraps at 65535) is sampled into each record at capture.
  - It is appended as 2 bytes, MSB first, after rdata; frame length is 13 bytes.
- `TRACE_TIMESTAMP_EN` undefined: no counter, 11-byte frames.

## Test plan
- Reset check, CLKS_PER_BIT=4: hold `reset`=0 → `tx`=1, all status outputs 0. Release → `tx` stays 1 with no captures.
- Single store: wr=1, addr=9'h1A5, wr_data=32'hDEADBEEF for one cycle.
  - Frame bytes are 0x80, 0x01, 0xA5, DE, AD, BE, EF, 00, 00, 00, 00.
  - The first bit is sampled at 4-cycle intervals.
  - Total frame length is 440 cycles.
- Writeback to x0: reg_write_sig=1, reg_num=0, no wr/rd → no record, `fifo_level` stays 0. Same with reg_num=5, reg_data=32'h12345678 → header 0x25, last four bytes 12 34 56 78.
- Overflow, FIFO_DEPTH=4: five captures in five consecutive cycles while the first frame shifts.
  - The first capture is popped, so 4 are queued and none is dropped.
  - A sixth capture gives `overflow`=1 and `drop_count`=1.
  - 300 further drops leave `drop_count`=255.
- Reset mid-frame: assert `reset` during DATA of byte 3 → `tx`=1 asynchronously, FIFO empty. After release, no residual bytes are emitted.
- With `TRACE_TIMESTAMP_EN`: capture at cycle 70000 after reset → last two bytes 0x11, 0x70 (70000 mod 65536 = 4464 = 0x1170), frame length 520 cycles.

Source files
------------

// File: rtl/trace_uart_tx.sv
// Execution-trace UART transmitter: captured writeback/memory records are queued and sent as 8N1 byte frames.
// Optional TRACE_TIMESTAMP_EN appends a 16-bit capture timestamp (13-byte frames instead of 11).

// Generic show-ahead FIFO; the caller must not push when full (unless popping) or pop when empty.
// Latency: push visible at pop_dat one cycle after the push edge.
// Backpressure: none internally, level is exported so the caller decides.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  assign pop_dat = mem[rptr];
endmodule

// Qualifies core trace activity into records, buffers them, and serializes each as a UART frame.
// Latency: capture at edge N, start bit driven after edge N+1 when idle; frame = NBYTES*10*CLKS_PER_BIT cycles.
// Backpressure: none to the core; a capture into a full FIFO with no pop is dropped and counted.
module trace_uart_tx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trace_en,
  input  logic [4:0]                  reg_num,
  input  logic [DATA_W-1:0]           reg_data,
  input  logic                        reg_write_sig,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [8:0]                  addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [7:0]                  drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int NBYTES = 13;
`else
  localparam int NBYTES = 11;
`endif

  // Field order matches wire order, so the frame is simply the record sent MSB byte first.
  typedef struct packed {
    logic [7:0]  hdr;
    logic [7:0]  addr_hi;
    logic [7:0]  addr_lo;
    logic [31:0] mdata;
    logic [31:0] rdata;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts;
`endif
  } rec_t;

  localparam int FW = $bits(rec_t);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  rec_t              cap_rec;
  logic [FW-1:0]     pop_dat;
  logic [DATA_W-1:0] mdata_w;
  logic              rw_ok;
  logic              capture;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [1:0]        rst_sync;
  logic              run_ok;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [FW-1:0] frame;
  logic [7:0]    cur_byte;
  logic          last_tick;

`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts <= '0;
    else        ts <= ts + 16'd1;
  end
`endif

  assign rw_ok   = reg_write_sig && (reg_num != 5'd0);
  assign capture = trace_en && (wr || rd || rw_ok);
  assign mdata_w = wr ? wr_data : (rd ? rd_data : '0);

  always_comb begin
    cap_rec         = '0;
    cap_rec.hdr     = {wr, rd, rw_ok, reg_num};
    cap_rec.addr_hi = {7'd0, addr[8]};
    cap_rec.addr_lo = addr[7:0];
    cap_rec.mdata   = 32'(mdata_w);
    cap_rec.rdata   = 32'(reg_data);
`ifdef TRACE_TIMESTAMP_EN
    cap_rec.ts      = ts;
`endif
  end

  // Release is synchronized so the serializer never starts on a metastable reset edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run_ok = rst_sync[1];

  assign full = (fifo_level == LW'(FIFO_DEPTH));
  assign pop  = (state == IDLE) && run_ok && (fifo_level != '0);
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  trace_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (cap_rec),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .level    (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  assign cur_byte  = frame[FW-1 -: 8];
  assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      frame    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            frame    <= pop_dat;
            byte_idx <= '0;
            cnt      <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (last_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (last_tick) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (last_tick) begin
            cnt <= '0;
            if (byte_idx == 4'(NBYTES - 1)) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              frame    <= frame << 8;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (fifo_level != '0);
endmodule
